// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, the
// bubble encoding, the HALT opcode and the fetch state encoding.
package fetch_stage_pkg;

    localparam int          DEFAULT_PC_W      = 16;
    localparam int          DEFAULT_INSTR_W   = 16;
    localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0800;

    localparam int          OPCODE_W    = 5;
    localparam int          FUNCT_W     = 2;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [4:0]  NOP_OPCODE  = 5'b00001;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_WAIT   = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register (instruction, PC+2, valid) built from enabled
// synchronous-reset dff cells; flush inserts a bubble and beats load.

module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end
endmodule

module if_id_reg #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc_plus2,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    pc_plus2_q,
    output logic               valid_q
);

    logic               en;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_plus2_d;
    logic               valid_d;

    // A bubble clears PC+2 as well so a flushed slot matches the reset image.
    always_comb begin
        en         = flush | load;
        instr_d    = flush ? NOP_INSTR : instr;
        pc_plus2_d = flush ? '0 : pc_plus2;
        valid_d    = ~flush;
    end

    dff #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (instr_d),
        .q   (instr_q)
    );

    dff #(.W(PC_W), .RST_VAL('0)) u_pc_plus2 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (pc_plus2_d),
        .q   (pc_plus2_q)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (valid_d),
        .q   (valid_q)
    );

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and feeds
// the IF/ID register while handling stall, redirect, wait states and HALT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 PC_W      = DEFAULT_PC_W,
    parameter int                 INSTR_W   = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    RedirectPC,
    input  logic               Halt,
    input  logic [INSTR_W-1:0] IMemInstr,
    input  logic               IMemDone,
    output logic [PC_W-1:0]    IMemAddr,
    output logic               IMemEn,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [PC_W-1:0]    PCPlus2Out,
    output logic               ValidOut,
    output logic [OPCODE_W-1:0] OpCode,
    output logic [FUNCT_W-1:0]  Funct,
    output logic               Halted,
    output logic               err
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus2;
    logic            active;
    logic            take_redirect;
    logic            take_halt;
    logic            take_stall;
    logic            take_wait;
    logic            take_fetch;
    logic            if_id_load;
    logic            if_id_flush;

    // Event decode in priority order; HALTED masks everything except rst.
    always_comb begin
        active        = (state != ST_HALTED);
        take_redirect = active & Redirect;
        take_halt     = active & ~Redirect & Halt;
        take_stall    = active & ~Redirect & ~Halt & Stall;
        take_wait     = active & ~Redirect & ~Halt & ~Stall & ~IMemDone;
        take_fetch    = active & ~Redirect & ~Halt & ~Stall & IMemDone;
        pc_plus2      = pc + PC_W'(2);
        if_id_load    = take_fetch;
        if_id_flush   = take_redirect | take_halt | take_wait;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN, ST_WAIT: begin
                if (take_redirect)
                    state_next = ST_RUN;
                else if (take_halt)
                    state_next = ST_HALTED;
                else if (take_stall)
                    state_next = state;
                else if (take_wait)
                    state_next = ST_WAIT;
                else
                    state_next = ST_RUN;
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_comb begin
        IMemEn = 1'b1;
        Halted = 1'b0;
        case (state)
            ST_HALTED: begin
                IMemEn = 1'b0;
                Halted = 1'b1;
            end
            default: begin
                IMemEn = 1'b1;
                Halted = 1'b0;
            end
        endcase
    end

    // PC only moves on a redirect or a completed, unstalled fetch.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (take_redirect)
            pc <= RedirectPC;
        else if (take_fetch)
            pc <= pc_plus2;
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (if_id_load),
        .flush      (if_id_flush),
        .instr      (IMemInstr),
        .pc_plus2   (pc_plus2),
        .instr_q    (InstrOut),
        .pc_plus2_q (PCPlus2Out),
        .valid_q    (ValidOut)
    );

    always_comb begin
        IMemAddr = pc;
        OpCode   = InstrOut[15:11];
        Funct    = InstrOut[1:0];
        err      = IMemEn & pc[0];
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expectations are queued as each cycle is
// driven and compared after the edge; a second instance covers RESET_PC wrap.
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] addr;
        logic        en;
        logic [15:0] instr;
        logic [15:0] pcp2;
        logic        valid;
        logic        halted;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_done;

    logic [15:0] addr, instr_in, instr_out, pcp2_out;
    logic        en, valid, halted, err;
    logic [4:0]  opcode;
    logic [1:0]  funct;

    logic [15:0] w_addr, w_instr_in, w_instr_out, w_pcp2_out;
    logic        w_en, w_valid, w_halted, w_err;
    logic [4:0]  w_opcode;
    logic [1:0]  w_funct;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Memory image: mem[0]=4001, mem[2]=4002, mem[4]=4003, ... (11-bit index wraps).
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [10:0] idx;
        idx = a[11:1] + 11'd1;
        return 16'h4000 | {5'b0, idx};
    endfunction

    assign instr_in   = mem_word(addr);
    assign w_instr_in = mem_word(w_addr);

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (stall),
        .Redirect   (redirect),
        .RedirectPC (redirect_pc),
        .Halt       (halt),
        .IMemInstr  (instr_in),
        .IMemDone   (imem_done),
        .IMemAddr   (addr),
        .IMemEn     (en),
        .InstrOut   (instr_out),
        .PCPlus2Out (pcp2_out),
        .ValidOut   (valid),
        .OpCode     (opcode),
        .Funct      (funct),
        .Halted     (halted),
        .err        (err)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .Stall      (stall),
        .Redirect   (redirect),
        .RedirectPC (redirect_pc),
        .Halt       (halt),
        .IMemInstr  (w_instr_in),
        .IMemDone   (imem_done),
        .IMemAddr   (w_addr),
        .IMemEn     (w_en),
        .InstrOut   (w_instr_out),
        .PCPlus2Out (w_pcp2_out),
        .ValidOut   (w_valid),
        .OpCode     (w_opcode),
        .Funct      (w_funct),
        .Halted     (w_halted),
        .err        (w_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] i,
                                input logic [15:0] p, input logic v,
                                input logic e, input logic h, input logic er);
        exp_t x;
        x.addr = a; x.instr = i; x.pcp2 = p; x.valid = v;
        x.en = e; x.halted = h; x.err = er;
        return x;
    endfunction

    function automatic exp_t bubble(input logic [15:0] a, input logic er);
        return mk(a, 16'h0800, 16'h0000, 1'b0, 1'b1, 1'b0, er);
    endfunction

    // One clock: drive at negedge, queue expectation, compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic st,
                       input logic rd, input logic [15:0] rpc,
                       input logic h, input logic d, input exp_t ex);
        exp_t got;
        @(negedge clk);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        halt = h; imem_done = d;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".addr"},   32'(addr),      32'(got.addr));
        check({tag, ".en"},     32'(en),        32'(got.en));
        check({tag, ".instr"},  32'(instr_out), 32'(got.instr));
        check({tag, ".pcp2"},   32'(pcp2_out),  32'(got.pcp2));
        check({tag, ".valid"},  32'(valid),     32'(got.valid));
        check({tag, ".halted"}, 32'(halted),    32'(got.halted));
        check({tag, ".err"},    32'(err),       32'(got.err));
        check({tag, ".opcode"}, 32'(opcode),    32'(got.instr[15:11]));
        check({tag, ".funct"},  32'(funct),     32'(got.instr[1:0]));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        halt = 1'b0; imem_done = 1'b1;

        cyc("reset", 1, 0, 0, 16'h0, 0, 1, bubble(16'h0000, 0));
        check("wrap.reset_addr", 32'(w_addr), 32'hFFFE);
        check("wrap.reset_en",   32'(w_en),   32'h1);

        cyc("run1", 0, 0, 0, 16'h0, 0, 1, mk(16'h0002, 16'h4001, 16'h0002, 1, 1, 0, 0));
        check("wrap.addr",  32'(w_addr),      32'h0000);
        check("wrap.instr", 32'(w_instr_out), 32'h4000);
        check("wrap.pcp2",  32'(w_pcp2_out),  32'h0000);
        check("wrap.valid", 32'(w_valid),     32'h1);
        cyc("run2", 0, 0, 0, 16'h0, 0, 1, mk(16'h0004, 16'h4002, 16'h0004, 1, 1, 0, 0));

        for (int i = 0; i < 3; i++)
            cyc("stall", 0, 1, 0, 16'h0, 0, 1, mk(16'h0004, 16'h4002, 16'h0004, 1, 1, 0, 0));
        cyc("release", 0, 0, 0, 16'h0, 0, 1, mk(16'h0006, 16'h4003, 16'h0006, 1, 1, 0, 0));
        cyc("run3",    0, 0, 0, 16'h0, 0, 1, mk(16'h0008, 16'h4004, 16'h0008, 1, 1, 0, 0));

        cyc("redir_prio", 0, 1, 1, 16'h0100, 1, 1, bubble(16'h0100, 0));
        cyc("redir_to8",  0, 0, 1, 16'h0008, 0, 1, bubble(16'h0008, 0));

        cyc("wait1", 0, 0, 0, 16'h0, 0, 0, bubble(16'h0008, 0));
        cyc("wait2", 0, 0, 0, 16'h0, 0, 0, bubble(16'h0008, 0));
        cyc("wait_done", 0, 0, 0, 16'h0, 0, 1, mk(16'h000A, 16'h4005, 16'h000A, 1, 1, 0, 0));

        cyc("redir_20", 0, 0, 1, 16'h0020, 0, 1, bubble(16'h0020, 0));
        cyc("halt", 0, 0, 0, 16'h0, 1, 1, mk(16'h0020, 16'h0800, 16'h0000, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++) begin
            logic [3:0] k;
            k = 4'(i);
            cyc("halted", 0, k[1], k[0], 16'h0040, 0, 1,
                mk(16'h0020, 16'h0800, 16'h0000, 0, 0, 1, 0));
        end
        cyc("halt_rst", 1, 0, 0, 16'h0, 0, 1, bubble(16'h0000, 0));

        cyc("unaligned", 0, 0, 1, 16'h0003, 0, 1, bubble(16'h0003, 1));
        cyc("unal_fetch", 0, 0, 0, 16'h0, 0, 1, mk(16'h0005, 16'h4002, 16'h0005, 1, 1, 0, 1));
        cyc("unal_wait", 0, 0, 0, 16'h0, 0, 0, bubble(16'h0005, 1));
        cyc("wait_rst", 1, 0, 0, 16'h0, 0, 0, bubble(16'h0000, 0));
        cyc("post_rst", 0, 0, 0, 16'h0, 0, 1, mk(16'h0002, 16'h4001, 16'h0002, 1, 1, 0, 0));

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
